regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_W, `REG_ADDR_WIDTH (5), register address width.
- DATA_W, `REG_DATA_WIDTH (64), register data width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, sole clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- hold, input, 1, pipeline stall; blocks new grants.
- wb0_valid, input, 1, requester 0 (ALU) has a writeback.
- wb0_addr, input, ADDR_W, requester 0 destination.
- wb0_data, input, DATA_W, requester 0 result.
- wb0_ready, output, 1, requester 0 accepted this cycle.
- wb1_valid, input, 1, requester 1 (load unit) has a writeback.
- wb1_addr, input, ADDR_W, requester 1 destination.
- wb1_data, input, DATA_W, requester 1 result.
- wb1_ready, output, 1, requester 1 accepted this cycle.
- RegWrite, output, 1, register file write enable.
- write_reg_addr, output, ADDR_W, register file write address.
- write_reg_data, output, DATA_W, register file write data.
- rd_addr_1, input, ADDR_W, register file read port 1 address (snooped).
- rd_addr_2, input, ADDR_W, register file read port 2 address (snooped).
- fwd_hit_1, output, 1, staged write matches rd_addr_1.
- fwd_hit_2, output, 1, staged write matches rd_addr_2.
- fwd_data, output, DATA_W, staged write data for bypass.
REQ-003 Clock and reset SHALL be one clock (clk) with synchronous, active-high reset (reset); there SHALL be no asynchronous reset path.

Function
REQ-004 A request SHALL be accepted in cycle N iff its valid is high, its ready is high, and hold is low; ready SHALL be combinational from valid, hold and the priority pointer.
REQ-005 At most one ready SHALL be high per cycle; with hold high, both readies SHALL be low.
REQ-006 With one valid requester, that requester SHALL be granted.
REQ-007 With both valid, the requester other than last_grant SHALL be granted (two-way round-robin).
REQ-008 last_grant SHALL update only on an accepted request.
REQ-009 An accepted request SHALL be captured into a one-entry stage register (stg_valid, stg_addr, stg_data) at the end of cycle N.
REQ-010 RegWrite, write_reg_addr and write_reg_data SHALL be driven from the stage register in cycle N+1 (latency 1); RegWrite = stg_valid AND stg_addr != 0.
REQ-011 Writes to x0 SHALL be accepted, staged, and dropped; they SHALL never assert RegWrite or fwd_hit.
REQ-012 The stage register SHALL load every cycle; with no acceptance, stg_valid SHALL become 0 (no write repeated).
REQ-013 The register file always accepts writes, so back-pressure SHALL come only from hold and arbitration.
REQ-014 fwd_hit_k SHALL be stg_valid AND stg_addr != 0 AND rd_addr_k == stg_addr (combinational); fwd_data SHALL equal stg_data.
REQ-015 Both requesters valid with the same address SHALL be serialised in grant order; the later write wins in the register file.
REQ-016 hold asserted while stg_valid=1 SHALL NOT cancel the staged write; it still retires in the next cycle.

Reset
REQ-017 While reset is high, stg_valid SHALL be 0, stg_addr and stg_data 0, and last_grant 1 (requester 0 wins first contention).
REQ-018 While reset is high, all outputs SHALL read 0: RegWrite, wb0_ready, wb1_ready, fwd_hit_1, fwd_hit_2, write_reg_addr, write_reg_data, fwd_data.
REQ-019 Reset asserted mid-operation SHALL discard any staged write; that write SHALL never reach the register file.

Structure
REQ-020 `REG_ADDR_WIDTH, `REG_DATA_WIDTH and `REG_SIZE SHALL come from the shared const.v.
REQ-021 A new `WB_NUM_REQ (2) SHALL be added to const.v.
REQ-022 Grant logic SHALL be one sub-module, wb_rr_arbiter2 (inputs: valids, hold, accept; outputs: grants, last_grant state).
REQ-023 Staging and forwarding SHALL stay in the top module.

Verification
REQ-024 Single request: wb0 {x5, 0x11} alone at cycle 0 -> wb0_ready=1 at cycle 0; RegWrite=1, addr 5, data 0x11 at cycle 1; RegWrite=0 at cycle 2.
REQ-025 Contention: both valid for 4 cycles (wb0 x1, wb1 x2) after reset -> grants 0,1,0,1; writes x1,x2,x1,x2 on cycles 1-4.
REQ-026 Forwarding and x0: stage holds x7=0xAB with rd_addr_1=7 and rd_addr_2=3 -> fwd_hit_1=1, fwd_hit_2=0, fwd_data=0xAB. Stage holds x0 -> RegWrite=0 and fwd_hit both 0.
REQ-027 hold: wb1 valid with hold=1 for 3 cycles -> wb1_ready=0 throughout; a write staged before hold still retires.
REQ-028 Reset mid-operation: reset in the cycle after acceptance -> RegWrite=0 next cycle; first contention after reset grants requester 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter slice.
`include "const.v"

package regfile_wb_arbiter_pkg;
    localparam int WB_NUM = `WB_NUM_REQ;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;
endpackage

// File: rtl/const.v
// Shared architectural constants for the register file and its writeback path.
`ifndef CONST_V
`define CONST_V
`define REG_ADDR_WIDTH 5
`define REG_DATA_WIDTH 64
`define REG_SIZE 32
`define WB_NUM_REQ 2
`endif

// File: rtl/regfile_wb_arbiter_rr.sv
// Two-way round-robin grant logic for the writeback port.
`include "const.v"

module wb_rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [WB_NUM-1:0] valid,
    input  logic              hold,
    input  logic              accept,
    output logic [WB_NUM-1:0] grant,
    output wb_src_e           last_grant
);

    always_comb begin
        grant = '0;
        if (!hold) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                // On contention the requester that did not win last time goes first.
                2'b11:   grant = (last_grant == WB_LSU) ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= WB_LSU;
        end else if (accept) begin
            last_grant <= grant[1] ? WB_LSU : WB_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges ALU and load-unit results into one register file
// write port through a single stage register that also feeds the bypass network.
`include "const.v"

module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = `REG_ADDR_WIDTH,
    parameter int DATA_W = `REG_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              wb0_valid,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    output logic              wb0_ready,
    input  logic              wb1_valid,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              wb1_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write_reg_addr,
    output logic [DATA_W-1:0] write_reg_data,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic              fwd_hit_1,
    output logic              fwd_hit_2,
    output logic [DATA_W-1:0] fwd_data
);

    logic [WB_NUM-1:0] grant;
    logic              accept;
    wb_src_e           last_grant;

    logic              stg_valid;
    logic [ADDR_W-1:0] stg_addr;
    logic [DATA_W-1:0] stg_data;
    logic              stg_live;

    // Reset is folded into hold so no ready can be seen while reset is high.
    wb_rr_arbiter2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .valid      ({wb1_valid, wb0_valid}),
        .hold       (hold | reset),
        .accept     (accept),
        .grant      (grant),
        .last_grant (last_grant)
    );

    assign wb0_ready = grant[0];
    assign wb1_ready = grant[1];
    assign accept    = |grant;

    // Stage loads every cycle so a write is never repeated.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid <= 1'b0;
            stg_addr  <= '0;
            stg_data  <= '0;
        end else begin
            stg_valid <= accept;
            stg_addr  <= grant[1] ? wb1_addr : (grant[0] ? wb0_addr : '0);
            stg_data  <= grant[1] ? wb1_data : (grant[0] ? wb0_data : '0);
        end
    end

    // x0 writes are staged but never retire or forward.
    assign stg_live       = !reset && stg_valid && (stg_addr != '0);

    assign RegWrite       = stg_live;
    assign write_reg_addr = reset ? '0 : stg_addr;
    assign write_reg_data = reset ? '0 : stg_data;
    assign fwd_hit_1      = stg_live && (rd_addr_1 == stg_addr);
    assign fwd_hit_2      = stg_live && (rd_addr_2 == stg_addr);
    assign fwd_data       = reset ? '0 : stg_data;

endmodule
